// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared definitions for the bit-serial add/subtract sequencer:
//                FSM state encoding and the bit-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit-counter width: enough to count 0..w-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        int r;
        r = $clog2(w);
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
// ============================================================================
//  Module      : fulladder
//  Description : Full-adder cell; a + b + y -> sum s, carry c (bitwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module fulladder #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c
);

    // Sum and carry-out of the three inputs
    always_comb begin
        s = a ^ b ^ y;
        c = (a & b) | (y & (a ^ b));
    end

endmodule : fulladder
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial add/subtract sequencer. Operands are accepted via
//                valid/ready, fed LSB-first through one fulladder cell, and
//                the result is held behind a second valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);

    localparam int            CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             w_fa_s;
    logic             w_fa_c;

    // Single shared adder cell: one operand bit pair per RUN cycle
    fulladder #(
        .WIDTH (1)
    ) u_fa (
        .a (sa_q[0]),
        .b (sb_q[0]),
        .y (carry_q),
        .s (w_fa_s),
        .c (w_fa_c)
    );

    // Handshake/status outputs decode straight from state; in_ready is also
    // held low while reset is asserted. Results are only exposed in DONE so
    // intermediate carry/result activity never reaches the outputs.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && reset;
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        out_sum   = (state_q == ST_DONE) ? res_q : '0;
        out_carry = (state_q == ST_DONE) ? carry_q : 1'b0;
    end

    // Next-state logic for the FSM and the serial datapath
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1: invert B and seed the carry
                    sa_d    = in_a;
                    sb_d    = in_b ^ {WIDTH{in_sub}};
                    carry_d = in_sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                res_d   = {w_fa_s, res_q[WIDTH-1:1]};
                carry_d = w_fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    cnt_d   = cnt_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : serial_adder_ctrl
`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract sequencer built around the existing single-bit `fulladder` cell. It accepts two WIDTH-bit operands through a valid/ready handshake and feeds them LSB-first through one `fulladder` instance, one bit per clock, while holding the carry in a flop. It collects the sum bits into a shift register and presents the result through a second valid/ready handshake. It sits between the top-level I/O wrapper and the adder cell, and is the sequencing layer the multiplier datapath reuses for its partial-product accumulation.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; low forces the reset state immediately.
- `in_valid` input 1: operand word presented.
- `in_ready` output 1: block can accept operands.
- `in_a` input WIDTH: operand A.
- `in_b` input WIDTH: operand B.
- `in_sub` input 1: 0 = A+B, 1 = A−B.
- `out_valid` output 1: result held and valid.
- `out_ready` input 1: consumer takes the result.
- `out_sum` output WIDTH: sum or difference, modulo 2^WIDTH.
- `out_carry` output 1: carry out of the MSB. For subtract, 1 = no borrow.
- `busy` output 1: high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- In IDLE, `in_ready`=1.
- When `in_valid`&`in_ready` is seen at a rising edge, the block:
  - captures A into shift register `sa`;
  - captures B XOR {WIDTH{in_sub}} into `sb`;
  - sets the carry flop to `in_sub`;
  - clears bit counter `cnt`;
  - moves to RUN.
- In RUN, `fulladder` gets a=`sa[0]`, b=`sb[0]`, y=carry flop. Each edge:
  - `sa` and `sb` shift right;
  - `s` shifts into the MSB of the result register;
  - `c` loads the carry flop;
  - `cnt` increments.
- At the edge where `cnt`==WIDTH−1, the last bit is processed and the FSM moves to DONE.
- In DONE:
  - `out_valid`=1;
  - `out_sum` = result register;
  - `out_carry` = carry flop.
- When `out_valid`&`out_ready` is seen at an edge, the FSM moves to IDLE.
- `in_valid` is ignored outside IDLE (`in_ready`=0). Operands and `in_sub` are sampled only at the accept edge, so later input changes have no effect.
- Outputs are stable throughout DONE regardless of `out_ready` or inputs.
- Reset values:
  - state IDLE;
  - `in_ready`=1 once reset is deasserted (0 while reset is low);
  - `out_valid`=0, `busy`=0;
  - `out_sum`=0, `out_carry`=0;
  - all internal registers 0.
- Reset during RUN or DONE aborts the operation; no partial result is ever emitted.

## Timing
- Latency: `out_valid` rises WIDTH cycles after the accept edge. There are exactly WIDTH RUN cycles.
- Minimum initiation interval: WIDTH+2 cycles, made up of the accept cycle in IDLE, WIDTH RUN cycles and at least one DONE cycle.
- There is no combinational path from `out_ready` to `in_ready`. IDLE is always visited between operations.
- `out_ready` held high in advance gives a one-cycle DONE.
- `cnt` is $clog2(WIDTH) bits. It never wraps within an operation and is cleared at accept.
- Overflow is not flagged. The sum wraps modulo 2^WIDTH, with the carry reported separately.
- Reset assertion is asynchronous. Deassertion is synchronised externally by the top level; the block performs no deassertion synchronisation.

## Structure
- Shared package `serial_adder_pkg`:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - counter-width function.
- One sub-module: `fulladder` with WIDTH=1, instantiated unchanged.
- The FSM, shift registers, carry flop and counter live in `serial_adder_ctrl`.
- A top-level wrapper `top_serial_adder` maps the pins using the global/config bit-ID macros. It is out of scope for this block.

## Test plan
- WIDTH=8, add 0x5A+0x3C → `out_sum`=0x96, `out_carry`=0, `out_valid` exactly 8 cycles after accept.
- Add 0xFF+0x01 → `out_sum`=0x00, `out_carry`=1. Then sub 0x10−0x01 → 0x0F, carry 1.
- Sub 0x01−0x02 → `out_sum`=0xFF, `out_carry`=0 (borrow).
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_sum`/`out_carry` stable and `in_ready`=0 throughout. Raising `out_ready` gives IDLE the next cycle.
- Hold `in_valid`=1 with changing operands during RUN → result equals the operands captured at accept, and there is no second accept until IDLE.
- Assert `reset` low at RUN cycle 4 → outputs go to their reset values immediately. After release, `in_ready`=1 and a fresh 0x03+0x04 gives 0x07.
